// File: rtl/hvsync_generator.sv
// Free-running VGA raster timing: pixel/line counters plus sync and visible-area flags.
// Flags are registered from the next-state counters, so they stay in step with CounterX/CounterY.
module hvsync_generator #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       inDisplayArea,
   output logic [9:0] CounterX,
   output logic [9:0] CounterY
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] H_VISIBLE    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VISIBLE    = 11'(V_ACTIVE);

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       h_sync_q, h_sync_d;
   logic       v_sync_q, v_sync_d;
   logic       de_q, de_d;
   logic [10:0] x_ext, y_ext;

   always_comb begin
      x_d = x_q + 10'd1;
      y_d = y_q;
      if (x_q == H_LAST) begin
         x_d = 10'd0;
         if (y_q == V_LAST) begin
            y_d = 10'd0;
         end else begin
            y_d = y_q + 10'd1;
         end
      end
   end

   // Decode against the values the counters are about to take so flags line up with them.
   always_comb begin
      x_ext    = {1'b0, x_d};
      y_ext    = {1'b0, y_d};
      h_sync_d = ~((x_ext >= H_SYNC_FIRST) && (x_ext < H_SYNC_END));
      v_sync_d = ~((y_ext >= V_SYNC_FIRST) && (y_ext < V_SYNC_END));
      de_d     = (x_ext < H_VISIBLE) && (y_ext < V_VISIBLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q      <= 10'd0;
         y_q      <= 10'd0;
         h_sync_q <= 1'b1;
         v_sync_q <= 1'b1;
         de_q     <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         h_sync_q <= h_sync_d;
         v_sync_q <= v_sync_d;
         de_q     <= de_d;
      end
   end

   assign CounterX      = x_q;
   assign CounterY      = y_q;
   assign vga_h_sync    = h_sync_q;
   assign vga_v_sync    = v_sync_q;
   assign inDisplayArea = de_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: a default-timing instance and a shrunken one sharing one clock,
// each checked every cycle against a raster-position model, plus directed timing scenarios.
module tb_hvsync_generator;

   localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
   localparam int B_HA = 40,  B_HF = 4,  B_HS = 8,  B_HB = 4;
   localparam int B_VA = 20,  B_VF = 3,  B_VS = 2,  B_VB = 5;
   localparam int FRAME_A = 800 * 525;
   localparam int FRAME_B = 56 * 30;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
   logic [9:0] x_a, y_a, x_b, y_b;

   int vec_count = 0;
   int err_count = 0;

   int  n_a = 0, n_b = 0;
   bit  fresh_a = 1'b1, fresh_b = 1'b1;

   hvsync_generator dut_a (
      .clk(clk), .reset(rst_a),
      .vga_h_sync(hs_a), .vga_v_sync(vs_a), .inDisplayArea(de_a),
      .CounterX(x_a), .CounterY(y_a)
   );

   hvsync_generator #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
   ) dut_b (
      .clk(clk), .reset(rst_b),
      .vga_h_sync(hs_b), .vga_v_sync(vs_b), .inDisplayArea(de_b),
      .CounterX(x_b), .CounterY(y_b)
   );

   always #5 clk = ~clk;

   // Position n counts pixels since the start of a frame; outputs follow from the timing rules.
   function automatic exp_t model_at(input int n, input int ha, input int hf, input int hsy,
                                     input int hb, input int va, input int vf, input int vsy);
      exp_t e;
      int ht, x, y;
      ht   = ha + hf + hsy + hb;
      x    = n % ht;
      y    = n / ht;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.hs = !((x >= ha + hf) && (x < ha + hf + hsy));
      e.vs = !((y >= va + vf) && (y < va + vf + vsy));
      e.de = (x < ha) && (y < va);
      return e;
   endfunction

   function automatic exp_t reset_values();
      exp_t e;
      e.x  = 10'd0;
      e.y  = 10'd0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.de = 1'b0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [9:0] ax, input logic [9:0] ay,
                              input logic ahs, input logic avs, input logic ade, input exp_t e);
      vec_count++;
      if ({ax, ay, ahs, avs, ade} !== e) begin
         err_count++;
         $display("[TB] FAIL %s: got x=%0d y=%0d hs=%b vs=%b de=%b, expected x=%0d y=%0d hs=%b vs=%b de=%b",
                  name, ax, ay, ahs, avs, ade, e.x, e.y, e.hs, e.vs, e.de);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int expv);
      vec_count++;
      if (act != expv) begin
         err_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic waitFor(input bit use_b, input int x, input int y, input int budget,
                          input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (use_b) hit = (int'(x_b) == x) && (int'(y_b) == y);
         else       hit = (int'(x_a) == x) && (int'(y_a) == y);
      end
      vec_count++;
      if (!hit) begin
         err_count++;
         $display("[TB] FAIL %s: position %0d/%0d not reached within %0d cycles", name, x, y, budget);
      end
   endtask

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         fresh_a <= 1'b1;
         n_a     <= 0;
      end else begin
         fresh_a <= 1'b0;
         n_a     <= (n_a + 1) % FRAME_A;
      end
   end

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fresh_b <= 1'b1;
         n_b     <= 0;
      end else begin
         fresh_b <= 1'b0;
         n_b     <= (n_b + 1) % FRAME_B;
      end
   end

   // Every cycle, both instances against the model, sampled midway between rising edges.
   always @(negedge clk) begin
      exp_t ea, eb;
      ea = fresh_a ? reset_values() : model_at(n_a, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS);
      eb = fresh_b ? reset_values() : model_at(n_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS);
      checkOutput("cycle_a", x_a, y_a, hs_a, vs_a, de_a, ea);
      checkOutput("cycle_b", x_b, y_b, hs_b, vs_b, de_b, eb);
   end

   task automatic applyStimulus();
      int h_low, h_first, h_last, period, v_low, v_first, v_last, hb_low, de_bad;

      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) @(negedge clk);
      checkValue("reset_x", int'(x_a), 0);
      checkValue("reset_y", int'(y_a), 0);
      checkValue("reset_hs", int'(hs_a), 1);
      checkValue("reset_vs", int'(vs_a), 1);
      checkValue("reset_de", int'(de_a), 0);
      #2;
      rst_a = 1'b1;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      checkValue("release_x", int'(x_a), 1);
      checkValue("release_y", int'(y_a), 0);
      checkValue("release_de", int'(de_a), 1);
      checkValue("release_b_x", int'(x_b), 1);

      waitFor(1'b0, 0, 1, 1000, "a_line1");
      h_low = 0;
      h_first = -1;
      h_last = -1;
      for (int i = 0; i < 800; i++) begin
         if (!hs_a) begin
            h_low++;
            if (h_first < 0) h_first = int'(x_a);
            h_last = int'(x_a);
         end
         if (x_a == 10'd639) checkValue("de_at_639", int'(de_a), 1);
         if (x_a == 10'd640) checkValue("de_at_640", int'(de_a), 0);
         @(negedge clk);
      end
      checkValue("hsync_low_clocks", h_low, 96);
      checkValue("hsync_first_x", h_first, 656);
      checkValue("hsync_last_x", h_last, 751);

      waitFor(1'b0, 799, 5, 4000, "a_line5_end");
      @(posedge clk);
      #1;
      checkValue("line_wrap_x", int'(x_a), 0);
      checkValue("line_wrap_y", int'(y_a), 6);

      waitFor(1'b1, 0, 0, 2000, "b_frame_start");
      period = 0;
      v_low = 0;
      v_first = -1;
      v_last = -1;
      hb_low = 0;
      de_bad = 0;
      do begin
         if (!vs_b) begin
            v_low++;
            if (v_first < 0) v_first = int'(y_b);
            v_last = int'(y_b);
         end
         if (!hs_b) hb_low++;
         if (y_b >= 10'd20 && de_b) de_bad++;
         @(negedge clk);
         period++;
      end while (!(x_b == 10'd0 && y_b == 10'd0) && period < 3000);
      checkValue("b_frame_period", period, 1680);
      checkValue("b_vsync_low_clocks", v_low, 112);
      checkValue("b_vsync_first_y", v_first, 23);
      checkValue("b_vsync_last_y", v_last, 24);
      checkValue("b_hsync_low_clocks", hb_low, 240);
      checkValue("b_de_in_vblank", de_bad, 0);

      waitFor(1'b1, 55, 29, 2000, "b_frame_end");
      @(posedge clk);
      #1;
      checkValue("frame_wrap_x", int'(x_b), 0);
      checkValue("frame_wrap_y", int'(y_b), 0);
      checkValue("frame_wrap_de", int'(de_b), 1);

      waitFor(1'b1, 30, 12, 2000, "b_mid_frame");
      #2;
      rst_b = 1'b0;
      #1;
      checkValue("mid_reset_x", int'(x_b), 0);
      checkValue("mid_reset_y", int'(y_b), 0);
      checkValue("mid_reset_hs", int'(hs_b), 1);
      checkValue("mid_reset_vs", int'(vs_b), 1);
      checkValue("mid_reset_de", int'(de_b), 0);
      repeat (3) @(negedge clk);
      #2;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      checkValue("restart_x", int'(x_b), 1);
      checkValue("restart_y", int'(y_b), 0);
      checkValue("restart_de", int'(de_b), 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      applyStimulus();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/hvsync_generator.md
HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, giving visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, giving horizontal front-porch clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, giving horizontal sync-pulse clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, giving horizontal back-porch clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, giving visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, giving vertical front-porch lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, giving vertical sync-pulse lines.
REQ-008 The block SHALL have parameter V_BP, default 33, giving vertical back-porch lines.
REQ-009 The block SHALL have port clk, input, 1 bit: the pixel clock (25 MHz nominal); it is the only clock.
REQ-010 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-011 The block SHALL have port vga_h_sync, output, 1 bit: horizontal sync, active-low.
REQ-012 The block SHALL have port vga_v_sync, output, 1 bit: vertical sync, active-low.
REQ-013 The block SHALL have port inDisplayArea, output, 1 bit: high while the current pixel is visible.
REQ-014 The block SHALL have port CounterX, output, 10 bits: the current pixel column.
REQ-015 The block SHALL have port CounterY, output, 10 bits: the current line.

Function
REQ-016 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both totals SHALL be at most 1024.
REQ-017 On every rising clk edge out of reset, CounterX SHALL increment by 1; when CounterX = H_TOTAL-1 it SHALL wrap to 0 on that edge.
REQ-018 CounterY SHALL increment by 1 only on the edge where CounterX wraps; when CounterY = V_TOTAL-1 on that edge it SHALL wrap to 0 (frame end: from 799/524 to 0/0).
REQ-019 CounterX and CounterY SHALL never leave the ranges 0..H_TOTAL-1 and 0..V_TOTAL-1.
REQ-020 vga_h_sync SHALL be 0 exactly while H_ACTIVE+H_FP <= CounterX <= H_ACTIVE+H_FP+H_SYNC-1 (default 656..751), and 1 otherwise.
REQ-021 vga_v_sync SHALL be 0 exactly while V_ACTIVE+V_FP <= CounterY <= V_ACTIVE+V_FP+V_SYNC-1 (default 490..491), for every CounterX value on those lines, and 1 otherwise.
REQ-022 inDisplayArea SHALL be 1 exactly when CounterX < H_ACTIVE and CounterY < V_ACTIVE.
REQ-023 All outputs SHALL be driven from flip-flops, with no combinational path from an input to an output.
REQ-024 vga_h_sync, vga_v_sync and inDisplayArea SHALL be aligned with the CounterX/CounterY values shown in the same cycle, with zero lag; they SHALL be computed from the next-state counter values.
REQ-025 All outputs SHALL be glitch-free, changing only on clk rising edges or on reset assertion.
REQ-026 With default parameters, a line SHALL be 800 clocks and a frame SHALL be 420000 clocks.

Reset
REQ-027 While reset = 0, the block SHALL hold CounterX = 0, CounterY = 0, vga_h_sync = 1, vga_v_sync = 1 and inDisplayArea = 0; these values SHALL take effect immediately on reset assertion, without waiting for a clock edge.
REQ-028 On the first rising clk edge after reset returns to 1, the block SHALL load CounterX = 1, CounterY = 0 and inDisplayArea = 1, and counting SHALL continue per REQ-017.
REQ-029 Reset asserted mid-frame SHALL abort the frame, and timing SHALL restart from REQ-028 after release.

Verification
REQ-030 Bench scenario, reset: hold reset = 0 for 5 clocks -> CounterX = 0, CounterY = 0, both syncs = 1, inDisplayArea = 0; release -> next edge gives CounterX = 1, inDisplayArea = 1.
REQ-031 Bench scenario, horizontal timing: run one line -> vga_h_sync is low for exactly 96 clocks starting at CounterX = 656; inDisplayArea falls when CounterX goes 639 -> 640.
REQ-032 Bench scenario, line wrap: at CounterX = 799, CounterY = 5 -> next edge gives CounterX = 0, CounterY = 6.
REQ-033 Bench scenario, frame wrap: at CounterX = 799, CounterY = 524 -> next edge gives 0/0 with inDisplayArea = 1; the measured frame period is 420000 clocks.
REQ-034 Bench scenario, vertical timing: vga_v_sync is low exactly for CounterY 490..491 (1600 clocks); inDisplayArea stays 0 for all of CounterY 480..524.
REQ-035 Bench scenario, reset mid-operation: assert reset at CounterX = 300, CounterY = 200 between clock edges -> outputs go to reset values without a clock edge; after release, counting restarts at 1/0.
